// File: rtl/savestate_req_seq_pkg.sv
// Shared types and constants for the savestate request sequencer.
package savestate_req_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PAUSE_WAIT,
        START,
        RUN,
        RELEASE
    } state_t;

    localparam logic [7:0] INFO_SLOT_EMPTY     = 8'd15;
    localparam logic [7:0] INFO_REQ_DROPPED    = 8'd16;
    localparam logic [7:0] INFO_PAUSE_TIMEOUT  = 8'd17;
    localparam logic [7:0] INFO_ENGINE_TIMEOUT = 8'd18;

    typedef struct packed {
        logic       load;
        logic [1:0] slot;
    } cmd_t;

endpackage

// File: rtl/savestate_req_seq_buffer.sv
// Single-entry request buffer; a push onto a held entry overwrites it and flags a drop.
module savestate_req_buffer
    import savestate_req_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       push_load,
    input  logic [1:0] push_slot,
    input  logic       pop,
    output logic       valid,
    output logic       load,
    output logic [1:0] slot,
    output logic       drop_c
);

    cmd_t entry;

    // A pop in the same cycle frees the entry, so that push is not a drop
    assign drop_c = push && valid && !pop;
    assign load   = entry.load;
    assign slot   = entry.slot;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            entry <= '0;
        end else if (push) begin
            valid      <= 1'b1;
            entry.load <= push_load;
            entry.slot <= push_slot;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/savestate_req_seq.sv
// Savestate request sequencer: pause handshake, engine start/done tracking,
// slot occupancy map and OSD info codes.
module savestate_req_seq
    import savestate_req_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_BITS = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ss_save,
    input  logic       ss_load,
    input  logic [1:0] selected_slot,
    input  logic [3:0] slot_mark,
    output logic       pause_req,
    input  logic       pause_ack,
    output logic       sst_start,
    output logic       sst_load,
    output logic [1:0] sst_slot,
    input  logic       sst_done,
    output logic       busy,
    output logic [3:0] slot_valid,
    output logic       info_req,
    output logic [7:0] info_code
);

    state_t                  state, state_n;
    logic [TIMEOUT_BITS-1:0] wd, wd_n;
    logic                    sst_load_n;
    logic [1:0]              sst_slot_n;
    logic [3:0]              slot_valid_n;
    logic                    info_req_n;
    logic [7:0]              info_code_n;

    cmd_t req_cmd_c, pend_cmd, cand_c;
    logic req_c, push_c, pop_c, have_c, reject_c, timeout_c;
    logic pend_valid, pend_load, drop_c;
    logic [1:0] pend_slot;
    logic pause_to_c, eng_to_c;

    // Request decode: save wins over load; a held pending entry goes first
    always_comb begin
        req_c          = ss_save || ss_load;
        req_cmd_c.load = !ss_save;
        req_cmd_c.slot = selected_slot;
        pend_cmd.load  = pend_load;
        pend_cmd.slot  = pend_slot;
        push_c         = req_c && ((state != IDLE) || pend_valid);
        pop_c          = (state == IDLE) && pend_valid;
        have_c         = (state == IDLE) && (pend_valid || req_c);
        cand_c         = pend_valid ? pend_cmd : req_cmd_c;
        reject_c       = have_c && cand_c.load && !slot_valid[cand_c.slot];
        timeout_c      = wd[TIMEOUT_BITS-1];
    end

    savestate_req_buffer u_buffer (
        .clk       (clk),
        .reset     (reset),
        .push      (push_c),
        .push_load (req_cmd_c.load),
        .push_slot (req_cmd_c.slot),
        .pop       (pop_c),
        .valid     (pend_valid),
        .load      (pend_load),
        .slot      (pend_slot),
        .drop_c    (drop_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state, command capture, slot map and info selection
    always_comb begin
        state_n      = state;
        sst_load_n   = sst_load;
        sst_slot_n   = sst_slot;
        slot_valid_n = slot_valid | slot_mark;
        pause_to_c   = 1'b0;
        eng_to_c     = 1'b0;
        info_req_n   = 1'b0;
        info_code_n  = info_code;

        case (state)
            IDLE: begin
                if (have_c && !reject_c) begin
                    state_n    = PAUSE_WAIT;
                    sst_load_n = cand_c.load;
                    sst_slot_n = cand_c.slot;
                end
            end
            PAUSE_WAIT: begin
                if (pause_ack) begin
                    state_n = START;
                end else if (timeout_c) begin
                    pause_to_c = 1'b1;
                    state_n    = IDLE;
                end
            end
            START: state_n = RUN;
            RUN: begin
                if (sst_done) begin
                    if (!sst_load) begin
                        slot_valid_n[sst_slot] = 1'b1;
                    end
                    state_n = RELEASE;
                end else if (timeout_c) begin
                    eng_to_c = 1'b1;
                    state_n  = RELEASE;
                end
            end
            RELEASE: begin
                if (!pause_ack) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (eng_to_c) begin
            info_code_n = INFO_ENGINE_TIMEOUT;
        end else if (pause_to_c) begin
            info_code_n = INFO_PAUSE_TIMEOUT;
        end else if (drop_c) begin
            info_code_n = INFO_REQ_DROPPED;
        end else if (reject_c) begin
            info_code_n = INFO_SLOT_EMPTY;
        end
        info_req_n = eng_to_c || pause_to_c || drop_c || reject_c;

        // Watchdog restarts on every state change and only counts while waiting
        if (state_n != state) begin
            wd_n = '0;
        end else if ((state == PAUSE_WAIT) || (state == RUN)) begin
            wd_n = wd + TIMEOUT_BITS'(1);
        end else begin
            wd_n = wd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd         <= '0;
            pause_req  <= 1'b0;
            sst_start  <= 1'b0;
            sst_load   <= 1'b0;
            sst_slot   <= 2'd0;
            busy       <= 1'b0;
            slot_valid <= 4'd0;
            info_req   <= 1'b0;
            info_code  <= 8'd0;
        end else begin
            wd         <= wd_n;
            pause_req  <= (state_n == PAUSE_WAIT) || (state_n == START) || (state_n == RUN);
            sst_start  <= (state_n == START);
            sst_load   <= sst_load_n;
            sst_slot   <= sst_slot_n;
            busy       <= (state_n != IDLE);
            slot_valid <= slot_valid_n;
            info_req   <= info_req_n;
            info_code  <= info_code_n;
        end
    end

endmodule

// File: tb/tb_savestate_req_seq.sv
// Bench for savestate_req_seq: transaction-level reference model, per-cycle compare,
// directed scenarios followed by randomized traffic with a random core/engine responder.
module tb_savestate_req_seq;

    localparam int unsigned TB_BITS = 6;
    localparam int          HALF    = 1 << (TB_BITS - 1);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ss_save = 1'b0, ss_load = 1'b0;
    logic [1:0] selected_slot = 2'd0;
    logic [3:0] slot_mark = 4'd0;
    logic       pause_ack = 1'b0, sst_done = 1'b0;
    logic       pause_req, sst_start, sst_load, busy, info_req;
    logic [1:0] sst_slot;
    logic [3:0] slot_valid;
    logic [7:0] info_code;

    int vectors = 0;
    int miscompares = 0;
    int n_starts = 0;
    logic       last_load = 1'b0;
    logic [1:0] last_slot = 2'd0;

    savestate_req_seq #(.TIMEOUT_BITS(TB_BITS)) dut (
        .clk           (clk),
        .reset         (reset),
        .ss_save       (ss_save),
        .ss_load       (ss_load),
        .selected_slot (selected_slot),
        .slot_mark     (slot_mark),
        .pause_req     (pause_req),
        .pause_ack     (pause_ack),
        .sst_start     (sst_start),
        .sst_load      (sst_load),
        .sst_slot      (sst_slot),
        .sst_done      (sst_done),
        .busy          (busy),
        .slot_valid    (slot_valid),
        .info_req      (info_req),
        .info_code     (info_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. phase: 0 idle, 1 awaiting pause, 2 starting, 3 engine busy, 4 releasing
    int         ph = 0;
    int         tmr = 0;
    logic [2:0] q[$];
    logic       m_load = 1'b0;
    logic [1:0] m_slot = 2'd0;
    logic [3:0] m_valid = 4'd0;
    logic       m_info = 1'b0;
    logic [7:0] m_code = 8'd0;

    always @(posedge clk or posedge reset) begin : model
        int         code;
        int         prev;
        logic [2:0] nreq;
        logic [2:0] c;
        logic       got;
        if (reset) begin
            ph = 0; tmr = 0; q.delete();
            m_load = 1'b0; m_slot = 2'd0; m_valid = 4'd0; m_info = 1'b0; m_code = 8'd0;
        end else begin
            code = 0;
            got  = 1'b0;
            c    = 3'd0;
            nreq = {~ss_save, selected_slot};
            prev = ph;
            if (ph == 0) begin
                if (q.size() > 0) begin
                    c = q.pop_front();
                    got = 1'b1;
                    if (ss_save || ss_load) q.push_back(nreq);
                end else if (ss_save || ss_load) begin
                    c = nreq;
                    got = 1'b1;
                end
                if (got) begin
                    if (c[2] && !m_valid[c[1:0]]) code = 15;
                    else begin
                        m_load = c[2]; m_slot = c[1:0]; ph = 1;
                    end
                end
            end else begin
                if (ss_save || ss_load) begin
                    if (q.size() > 0) begin
                        code = 16;
                        q.delete();
                    end
                    q.push_back(nreq);
                end
                case (ph)
                    1: if (pause_ack) ph = 2;
                       else if (tmr == HALF) begin code = 17; ph = 0; end
                    2: ph = 3;
                    3: if (sst_done) begin
                           if (!m_load) m_valid[m_slot] = 1'b1;
                           ph = 4;
                       end else if (tmr == HALF) begin code = 18; ph = 4; end
                    4: if (!pause_ack) ph = 0;
                    default: ph = 0;
                endcase
            end
            tmr = (ph != prev) ? 0 : tmr + 1;
            m_valid = m_valid | slot_mark;
            m_info = (code != 0);
            if (code != 0) m_code = 8'(code);
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        chk("pause_req",  8'(pause_req),  8'(ph >= 1 && ph <= 3));
        chk("sst_start",  8'(sst_start),  8'(ph == 2));
        chk("sst_load",   8'(sst_load),   8'(m_load));
        chk("sst_slot",   8'(sst_slot),   8'(m_slot));
        chk("busy",       8'(busy),       8'(ph != 0));
        chk("slot_valid", 8'(slot_valid), 8'(m_valid));
        chk("info_req",   8'(info_req),   8'(m_info));
        chk("info_code",  info_code,      m_code);
        if (sst_start) begin
            n_starts++;
            last_load = sst_load;
            last_slot = sst_slot;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic sv, input logic ld, input logic [1:0] s);
        ss_save = sv; ss_load = ld; selected_slot = s;
        @(negedge clk);
        ss_save = 1'b0; ss_load = 1'b0;
    endtask

    int   n0;
    logic stubborn;
    int   done_div;

    initial begin
        cyc(2);
        chk("rst_pause_req", 8'(pause_req), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_info_code", info_code, 8'd0);
        reset = 1'b0;

        // save to slot 2
        req(1'b1, 1'b0, 2'd2);
        chk("save_pause_req", 8'(pause_req), 8'd1);
        chk("save_busy", 8'(busy), 8'd1);
        cyc(4); pause_ack = 1'b1; cyc(1);
        chk("save_start", 8'(sst_start), 8'd1);
        chk("save_mode", 8'(sst_load), 8'd0);
        chk("save_slot", 8'(sst_slot), 8'd2);
        cyc(1);
        chk("start_width", 8'(sst_start), 8'd0);
        cyc(18); sst_done = 1'b1; cyc(1); sst_done = 1'b0;
        chk("save_release", 8'(pause_req), 8'd0);
        chk("save_valid", 8'(slot_valid), 8'h4);
        pause_ack = 1'b0; cyc(2);
        chk("save_idle", 8'(busy), 8'd0);

        // load of an empty slot
        req(1'b0, 1'b1, 2'd1);
        chk("empty_info_req", 8'(info_req), 8'd1);
        chk("empty_info_code", info_code, 8'd15);
        chk("empty_no_pause", 8'(pause_req), 8'd0);
        sst_done = 1'b1; cyc(1); sst_done = 1'b0;
        chk("stray_done_busy", 8'(busy), 8'd0);
        chk("stray_done_valid", 8'(slot_valid), 8'h4);

        // mark slot 1 then load it
        slot_mark = 4'b0010; cyc(1); slot_mark = 4'd0;
        req(1'b0, 1'b1, 2'd1);
        chk("load_busy", 8'(busy), 8'd1);
        pause_ack = 1'b1; cyc(1);
        chk("load_start", 8'(sst_start), 8'd1);
        chk("load_mode", 8'(sst_load), 8'd1);
        chk("load_slot", 8'(sst_slot), 8'd1);
        cyc(3); sst_done = 1'b1; cyc(1); sst_done = 1'b0; pause_ack = 1'b0; cyc(2);
        chk("load_valid", 8'(slot_valid), 8'h6);
        chk("load_idle", 8'(busy), 8'd0);

        // pause acknowledge never arrives
        req(1'b1, 1'b0, 2'd3);
        cyc(32);
        chk("pto_still_busy", 8'(busy), 8'd1);
        chk("pto_no_info_yet", 8'(info_req), 8'd0);
        cyc(1);
        chk("pto_idle", 8'(busy), 8'd0);
        chk("pto_pause_req", 8'(pause_req), 8'd0);
        chk("pto_info_req", 8'(info_req), 8'd1);
        chk("pto_info_code", info_code, 8'd17);

        // overwrite of a pending request
        slot_mark = 4'b1000; cyc(1); slot_mark = 4'd0;
        n0 = n_starts;
        req(1'b1, 1'b0, 2'd2); pause_ack = 1'b1; cyc(1);
        req(1'b1, 1'b0, 2'd0);
        req(1'b0, 1'b1, 2'd3);
        chk("drop_info_req", 8'(info_req), 8'd1);
        chk("drop_info_code", info_code, 8'd16);
        cyc(2); sst_done = 1'b1; cyc(1); sst_done = 1'b0; pause_ack = 1'b0; cyc(3);
        chk("pending_taken", 8'(pause_req), 8'd1);
        pause_ack = 1'b1; cyc(3); sst_done = 1'b1; cyc(1); sst_done = 1'b0; pause_ack = 1'b0; cyc(4);
        chk("drop_start_count", 8'(n_starts - n0), 8'd2);
        chk("drop_last_mode", 8'(last_load), 8'd1);
        chk("drop_last_slot", 8'(last_slot), 8'd3);
        chk("drop_valid", 8'(slot_valid), 8'hE);

        // simultaneous pulses, then reset while the engine runs
        req(1'b1, 1'b1, 2'd1); pause_ack = 1'b1; cyc(1);
        chk("both_start", 8'(sst_start), 8'd1);
        chk("both_mode", 8'(sst_load), 8'd0);
        chk("both_slot", 8'(sst_slot), 8'd1);
        cyc(2);
        #2 reset = 1'b1;
        #1;
        chk("arst_pause_req", 8'(pause_req), 8'd0);
        chk("arst_busy", 8'(busy), 8'd0);
        chk("arst_start", 8'(sst_start), 8'd0);
        chk("arst_mode", 8'(sst_load), 8'd0);
        chk("arst_slot", 8'(sst_slot), 8'd0);
        chk("arst_valid", 8'(slot_valid), 8'd0);
        chk("arst_info_req", 8'(info_req), 8'd0);
        chk("arst_info_code", info_code, 8'd0);
        pause_ack = 1'b0;
        @(negedge clk); reset = 1'b0;
        cyc(2);

        // randomized traffic
        stubborn = 1'b0;
        done_div = 6;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (c % 200 == 0) begin
                stubborn = ($urandom_range(0, 3) == 0);
                done_div = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 12));
            end
            if ((pause_ack != pause_req) && (!pause_req || !stubborn) && ($urandom_range(0, 5) == 0))
                pause_ack = pause_req;
            sst_done = (done_div != 0) && ($urandom_range(0, done_div) == 0);
            ss_save = ($urandom_range(0, 11) == 0);
            ss_load = ($urandom_range(0, 9) == 0);
            selected_slot = 2'($urandom);
            slot_mark = ($urandom_range(0, 39) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'd0;
            if ($urandom_range(0, 999) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                #2 reset = 1'b0;
            end
        end

        ss_save = 1'b0; ss_load = 1'b0; slot_mark = 4'd0; sst_done = 1'b0;
        cyc(3);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
